img_pixel_buffer: RTL and testbench
===================================

Name: img_pixel_buffer

Overview:
- Image scratchpad between the memory-reader stage and the convolution PE.
- Accepts packed image words, 4 pixels per word, while the reader's img_wr_en is high.
- Stores them in a circular word buffer and serializes them to the PE as single pixels through a registered read port.
- Decouples the reader's burst timing from PE consumption.

Parameters:
DATA_W, 8, bits per pixel
PIX_PER_WORD, 4, pixels packed per input word (fixed at 4; lane counter is 2 bits)
DEPTH, 16, buffer capacity in words (power of two)
ADDR_W, 4, log2(DEPTH)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
clear  input  1  synchronous flush, priority over wr_en/rd_en
wr_en  input  1  write strobe (driven from reader img_wr_en)
wr_data  input  DATA_W*PIX_PER_WORD  packed word; pixel 0 in bits [DATA_W-1:0]
full  output  1  DEPTH words resident
rd_en  input  1  pixel read request from PE
rd_data  output  DATA_W  registered pixel
rd_valid  output  1  rd_data holds a newly read pixel this cycle
empty  output  1  no unread pixels
pix_count  output  ADDR_W+3  unread pixels (0..DEPTH*4)
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst low, async): wr_ptr=0, rd_ptr=0, lane=0, word_cnt=0; rd_data=0, rd_valid=0, empty=1, full=0, pix_count=0, overflow=0, underflow=0.
- clear=1 at an edge: same values as reset, including the sticky flags. wr_en/rd_en are ignored that cycle.
- Internal state:
  - word_cnt (0..DEPTH).
  - lane (0..3), the next pixel within the word at rd_ptr.
  - Pointers wrap modulo DEPTH.
- Flags:
  - full = (word_cnt==DEPTH).
  - empty = (word_cnt==0).
  - pix_count = word_cnt*4 - lane.
  - All derived from registered state; no combinational path from wr_en/rd_en.
- Write accepted when wr_en=1 and full=0 (pre-edge value): mem[wr_ptr]<=wr_data, wr_ptr++, word_cnt++.
- Write while full: data dropped, pointers unchanged, overflow<=1. A same-cycle read that frees a slot does NOT rescue the write.
- Read accepted when rd_en=1 and empty=0:
  - rd_data <= lane-th pixel of mem[rd_ptr]; rd_valid<=1 next cycle.
  - lane++. When lane was 3: lane<=0, rd_ptr++, word_cnt--.
- Read while empty: rd_valid<=0, rd_data holds its value, underflow<=1.
- No read accepted: rd_valid<=0 and rd_data holds.
- Latency:
  - Read: one cycle, rd_en at edge N gives rd_valid/rd_data after edge N.
  - Write-to-read: a word written at edge N drops empty after edge N, readable at edge N+1.
  - No bypass from wr_data to rd_data.
- Simultaneous accepted write and a word-completing read (lane 3): word_cnt unchanged, both pointers advance.
- Simultaneous accepted write and a non-completing read: word_cnt++, lane++.
- Pointer wrap: wr_ptr DEPTH-1 -> 0 and rd_ptr DEPTH-1 -> 0 with no data corruption. Order is strict FIFO by word, then lane 0..3.
- Memory contents are not cleared by reset/clear; only pointers are.
- Read FSM states (2-bit):
  - EMPTY: word_cnt==0.
  - STREAM: 0<word_cnt<DEPTH.
  - FULLST: word_cnt==DEPTH.
  - Transitions follow the registered word_cnt after each edge.
  - Outputs empty/full decode directly from state.
  - Reset and clear force EMPTY.

Test Plan:
- Reset then single write of 32'h44332211, rd_en high 4 cycles -> rd_data 8'h11,8'h22,8'h33,8'h44 on consecutive cycles with rd_valid=1; then empty=1, pix_count=0, underflow=0.
- Write 16 words (word k = {4{8'(k)}}) -> full=1 after 16th, pix_count=64. 17th write -> dropped, overflow=1, pix_count=64. Drain 64 pixels -> values 0x00 x4 .. 0x0F x4 in order.
- Fill 16 words, then wr_en and rd_en together for 8 cycles while lane reaches 3 -> exactly one extra word accepted only when not full at the edge; overflow set on the first full-edge write.
- Wrap: write 12, read 48 pixels, write 12 more, read 48 -> second batch emerges intact across rd_ptr 15->0; empty=1 at end.
- rd_en on empty buffer after reset -> rd_valid=0, rd_data=0, underflow=1. Write one word -> empty=0 the following cycle, underflow stays 1 until clear.
- Mid-stream: after 5 pixels read from 3 written words, assert rst low asynchronously between edges -> all outputs return to reset values immediately. Same sequence with clear=1 plus wr_en=1 -> word not stored, pix_count=0.

Source files
------------

// File: rtl/img_pixel_buffer.sv
// img_pixel_buffer: circular word buffer between the memory reader and the
// convolution PE. Packed 4-pixel words go in, single pixels come out through
// a registered read port, strictly in FIFO order (word, then lane 0..3).
module img_pixel_buffer #(
    parameter int DATA_W       = 8,
    parameter int PIX_PER_WORD = 4,
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           wr_en,
    input  logic [DATA_W*PIX_PER_WORD-1:0] wr_data,
    output logic                           full,
    input  logic                           rd_en,
    output logic [DATA_W-1:0]              rd_data,
    output logic                           rd_valid,
    output logic                           empty,
    output logic [ADDR_W+2:0]              pix_count,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int               WORD_W    = DATA_W * PIX_PER_WORD;
    localparam logic [ADDR_W:0]  DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        STREAM = 2'd1,
        FULLST = 2'd2
    } state_e;

    logic [WORD_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [1:0]        lane_q,     lane_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic [DATA_W-1:0] rd_data_q,  rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              ovf_q,      ovf_d;
    logic              udf_q,      udf_d;
    state_e            state_q,    state_d;

    logic              wr_acc, rd_acc, word_done, mem_we;
    logic [WORD_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_pix;

    // Flags come only from registered state, so wr_en/rd_en never reach them.
    assign empty     = (state_q == EMPTY);
    assign full      = (state_q == FULLST);
    assign pix_count = {word_cnt_q, 2'b00} - {{(ADDR_W+1){1'b0}}, lane_q};
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

    assign rd_word = mem_q[rd_ptr_q];
    assign rd_pix  = rd_word[lane_q*DATA_W +: DATA_W];

    // Next-state: accept decisions use pre-edge full/empty, clear wins over all.
    always_comb begin
        wr_acc     = wr_en && !full;
        rd_acc     = rd_en && !empty;
        word_done  = rd_acc && (lane_q == 2'd3);
        mem_we     = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        lane_d     = lane_q;
        word_cnt_d = word_cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        ovf_d      = ovf_q;
        udf_d      = udf_q;

        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            lane_d     = '0;
            word_cnt_d = '0;
            rd_data_d  = '0;
            ovf_d      = 1'b0;
            udf_d      = 1'b0;
        end else begin
            // A read that frees a slot this edge does not rescue a write.
            if (wr_en && full) ovf_d = 1'b1;
            if (rd_en && empty) udf_d = 1'b1;
            if (wr_acc) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_data_d  = rd_pix;
                rd_valid_d = 1'b1;
                lane_d     = lane_q + 2'd1;
                if (word_done) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            case ({wr_acc, word_done})
                2'b10:   word_cnt_d = word_cnt_q + (ADDR_W+1)'(1);
                2'b01:   word_cnt_d = word_cnt_q - (ADDR_W+1)'(1);
                default: word_cnt_d = word_cnt_q;
            endcase
        end

        if (word_cnt_d == '0)            state_d = EMPTY;
        else if (word_cnt_d == DEPTH_CNT) state_d = FULLST;
        else                              state_d = STREAM;
    end

    // Control state, read port, sticky flags and read FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            lane_q     <= '0;
            word_cnt_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            state_q    <= EMPTY;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            lane_q     <= lane_d;
            word_cnt_q <= word_cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            state_q    <= state_d;
        end
    end

    // Word storage; contents survive reset and clear, only pointers move.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: tb/tb_img_pixel_buffer.sv
// Bench for img_pixel_buffer: a word-queue reference model predicts each
// cycle's read result, which is queued at drive time and compared after the edge.
module tb_img_pixel_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        full;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        empty;
    logic [6:0]  pix_count;
    logic        overflow;
    logic        underflow;

    img_pixel_buffer #(.DATA_W(8), .PIX_PER_WORD(4), .DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .empty(empty), .pix_count(pix_count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_err = 0;
    string phase = "init";

    // reference model
    logic [31:0] mw[$];
    int          m_lane;
    logic        m_ov, m_un, m_vld;
    logic [7:0]  m_dat;
    logic [8:0]  sbq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s [%s] got=%0h exp=%0h t=%0t", tag, phase, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        mw.delete();
        m_lane = 0;
        m_ov   = 1'b0;
        m_un   = 1'b0;
        m_vld  = 1'b0;
        m_dat  = 8'h00;
    endtask

    task automatic check_flags();
        chk("empty",     32'(empty),     32'(mw.size() == 0));
        chk("full",      32'(full),      32'(mw.size() == 16));
        chk("pix_count", 32'(pix_count), 32'(mw.size() * 4 - m_lane));
        chk("overflow",  32'(overflow),  32'(m_ov));
        chk("underflow", 32'(underflow), 32'(m_un));
    endtask

    // One clock: drive inputs, predict, wait past the edge, compare.
    task automatic cyc(input logic we, input logic [31:0] wd, input logic re, input logic clr);
        logic        pf, pe;
        logic [31:0] w;
        logic [8:0]  e;
        wr_en = we; wr_data = wd; rd_en = re; clear = clr;
        if (clr) begin
            m_reset();
        end else begin
            pf = (mw.size() == 16);
            pe = (mw.size() == 0);
            if (re && !pe) begin
                w     = mw[0];
                m_dat = w[m_lane*8 +: 8];
                m_vld = 1'b1;
                if (m_lane == 3) begin
                    w = mw.pop_front();
                    m_lane = 0;
                end else begin
                    m_lane++;
                end
            end else begin
                m_vld = 1'b0;
                if (re) m_un = 1'b1;
            end
            if (we) begin
                if (!pf) mw.push_back(wd);
                else     m_ov = 1'b1;
            end
        end
        sbq.push_back({m_vld, m_dat});
        @(posedge clk);
        #1;
        chk("sb_depth", 32'(sbq.size()), 32'd1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("rd_valid", 32'(rd_valid), 32'(e[8]));
            chk("rd_data",  32'(rd_data),  32'(e[7:0]));
        end
        check_flags();
        wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
    endtask

    task automatic async_reset_pulse();
        #2 rst = 1'b0;
        m_reset();
        #1;
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data",  32'(rd_data),  32'd0);
        check_flags();
        #1 rst = 1'b1;
    endtask

    task automatic write_n(input int n, input int base);
        for (int k = 0; k < n; k++) begin
            logic [7:0] b;
            b = 8'(base + k);
            cyc(1'b1, {4{b}}, 1'b0, 1'b0);
        end
    endtask

    task automatic read_n(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        m_reset();
        #1;
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_rd_data",  32'(rd_data),  32'd0);
        check_flags();
        #11 rst = 1'b1;

        phase = "single_word";
        cyc(1'b1, 32'h44332211, 1'b0, 1'b0);
        read_n(4);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);

        phase = "fill_overflow_drain";
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        write_n(16, 0);
        cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        read_n(64);

        phase = "full_wr_rd";
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        write_n(16, 8'h40);
        for (int k = 0; k < 8; k++) cyc(1'b1, {4{8'(8'hA0 + k)}}, 1'b1, 1'b0);
        read_n(70);

        phase = "wrap";
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        write_n(12, 8'h10);
        read_n(48);
        write_n(12, 8'h80);
        read_n(48);

        phase = "underflow";
        async_reset_pulse();
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);

        phase = "mid_async_reset";
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        write_n(3, 8'h21);
        read_n(5);
        async_reset_pulse();
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        phase = "mid_clear";
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        write_n(3, 8'h31);
        read_n(5);
        cyc(1'b1, 32'h99999999, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        phase = "random";
        for (int k = 0; k < 400; k++) begin
            cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 60) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
